// File: rtl/qsn_pc51_pkg.sv
// Shared constants and helpers for the Pc=51 quasi-cyclic shift network controllers.
package qsn_pc51_pkg;

  localparam int PC         = 51;
  localparam int SHIFT_W    = 6;
  localparam int MERGE_W    = 50;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 4;

  localparam logic [SHIFT_W-1:0] PC_S = SHIFT_W'(PC);

  // Low k bits set for k in 1..50; zero for k == 0 or any out-of-range k.
  function automatic logic [MERGE_W-1:0] merge_mask(input logic [SHIFT_W-1:0] k);
    logic [MERGE_W-1:0] m;
    m = '0;
    for (int i = 0; i < MERGE_W; i++) begin
      m[i] = (k <= SHIFT_W'(MERGE_W)) && (i < int'(k));
    end
    return m;
  endfunction

endpackage

// File: rtl/qsn_shift_fifo.sv
// Small synchronous FIFO holding forward shift factors until the reverse pass consumes them.
module qsn_shift_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Head is read combinationally so a pop reaches the output registers in one cycle.
  assign head_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/qsn_deperm_ctrl_pc51.sv
// Reverse QSN controller: queues forward shift factors and replays their inverse circulant selects.
module qsn_deperm_ctrl_pc51
  import qsn_pc51_pkg::*;
(
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               fwd_valid,
  input  logic [SHIFT_W-1:0] fwd_shift,
  output logic               fwd_ready,
  input  logic               rev_req,
  output logic               rev_valid,
  output logic [SHIFT_W-1:0] inv_shift,
  output logic [SHIFT_W-1:0] left_sel,
  output logic [SHIFT_W-1:0] right_sel,
  output logic [MERGE_W-1:0] merge_sel,
  output logic [CNT_W-1:0]   occupancy,
  output logic               err_range,
  output logic               err_underflow
);

  logic [SHIFT_W-1:0] push_data;
  logic [SHIFT_W-1:0] head_s;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_ok;
  logic               pop_ok;
  logic [SHIFT_W-1:0] inv_next;
  logic [SHIFT_W-1:0] right_next;

  logic               rev_valid_reg;
  logic [SHIFT_W-1:0] inv_shift_reg;
  logic [SHIFT_W-1:0] left_sel_reg;
  logic [SHIFT_W-1:0] right_sel_reg;
  logic [MERGE_W-1:0] merge_sel_reg;
  logic               err_range_reg;
  logic               err_underflow_reg;

  assign fwd_ready = !fifo_full;
  assign push_ok   = fwd_valid && !fifo_full && !flush;
  assign pop_ok    = rev_req && !fifo_empty && !flush;

  // Out-of-range factors are replaced by a zero shift so the reverse pass stays well-defined.
  assign push_data = (fwd_shift < PC_S) ? fwd_shift : '0;

  assign inv_next   = (head_s == '0) ? '0 : PC_S - head_s;
  assign right_next = (inv_next == '0) ? '0 : PC_S - inv_next;

  qsn_shift_fifo #(
    .W     (SHIFT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (rst),
    .flush     (flush),
    .push      (fwd_valid),
    .push_data (push_data),
    .pop       (rev_req),
    .head_data (head_s),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rev_valid_reg     <= 1'b0;
      inv_shift_reg     <= '0;
      left_sel_reg      <= '0;
      right_sel_reg     <= '0;
      merge_sel_reg     <= '0;
      err_range_reg     <= 1'b0;
      err_underflow_reg <= 1'b0;
    end else begin
      rev_valid_reg <= pop_ok;
      // Selects hold between pops because the reverse shifter is purely combinational.
      if (pop_ok) begin
        inv_shift_reg <= inv_next;
        left_sel_reg  <= inv_next;
        right_sel_reg <= right_next;
        merge_sel_reg <= (inv_next == '0) ? '0 : merge_mask(PC_S - inv_next);
      end
      if (push_ok && (fwd_shift >= PC_S)) err_range_reg <= 1'b1;
      if (rev_req && fifo_empty && !flush) err_underflow_reg <= 1'b1;
    end
  end

  assign rev_valid     = rev_valid_reg;
  assign inv_shift     = inv_shift_reg;
  assign left_sel      = left_sel_reg;
  assign right_sel     = right_sel_reg;
  assign merge_sel     = merge_sel_reg;
  assign err_range     = err_range_reg;
  assign err_underflow = err_underflow_reg;

endmodule

// File: tb/tb_qsn_deperm_ctrl_pc51.sv
// Directed table, corner sequences and a randomized queue-model run for the reverse QSN controller.
module tb_qsn_deperm_ctrl_pc51;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        fwd_valid = 1'b0;
  logic [5:0]  fwd_shift = '0;
  logic        fwd_ready;
  logic        rev_req = 1'b0;
  logic        rev_valid;
  logic [5:0]  inv_shift;
  logic [5:0]  left_sel;
  logic [5:0]  right_sel;
  logic [49:0] merge_sel;
  logic [3:0]  occupancy;
  logic        err_range;
  logic        err_underflow;

  int total = 0;
  int bad = 0;

  localparam logic [49:0] ALL1 = 50'h3_FFFF_FFFF_FFFF;

  always #5 sys_clk = ~sys_clk;

  qsn_deperm_ctrl_pc51 dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .flush         (flush),
    .fwd_valid     (fwd_valid),
    .fwd_shift     (fwd_shift),
    .fwd_ready     (fwd_ready),
    .rev_req       (rev_req),
    .rev_valid     (rev_valid),
    .inv_shift     (inv_shift),
    .left_sel      (left_sel),
    .right_sel     (right_sel),
    .merge_sel     (merge_sel),
    .occupancy     (occupancy),
    .err_range     (err_range),
    .err_underflow (err_underflow)
  );

  typedef struct {
    logic        fv;
    logic [5:0]  fs;
    logic        rr;
    logic        fl;
    logic        rv;
    logic [5:0]  inv;
    logic [5:0]  lft;
    logic [5:0]  rgt;
    logic [49:0] mrg;
    logic [3:0]  occ;
    logic        rdy;
    logic        er;
    logic        eu;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic fv, input logic [5:0] fs, input logic rr, input logic fl,
                              input logic rv, input logic [5:0] inv, input logic [5:0] lft,
                              input logic [5:0] rgt, input logic [49:0] mrg, input logic [3:0] occ,
                              input logic rdy, input logic er, input logic eu);
    vec_t v;
    v.fv = fv; v.fs = fs; v.rr = rr; v.fl = fl; v.rv = rv; v.inv = inv; v.lft = lft;
    v.rgt = rgt; v.mrg = mrg; v.occ = occ; v.rdy = rdy; v.er = er; v.eu = eu;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, ".rev_valid"}, 64'(rev_valid), 64'(v.rv));
    check({tag, ".inv_shift"}, 64'(inv_shift), 64'(v.inv));
    check({tag, ".left_sel"}, 64'(left_sel), 64'(v.lft));
    check({tag, ".right_sel"}, 64'(right_sel), 64'(v.rgt));
    check({tag, ".merge_sel"}, 64'(merge_sel), 64'(v.mrg));
    check({tag, ".occupancy"}, 64'(occupancy), 64'(v.occ));
    check({tag, ".fwd_ready"}, 64'(fwd_ready), 64'(v.rdy));
    check({tag, ".err_range"}, 64'(err_range), 64'(v.er));
    check({tag, ".err_underflow"}, 64'(err_underflow), 64'(v.eu));
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic fv, input logic [5:0] fs, input logic rr, input logic fl);
    fwd_valid = fv; fwd_shift = fs; rev_req = rr; flush = fl;
    @(posedge sys_clk);
    #1;
    fwd_valid = 1'b0; rev_req = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fwd_valid = 1'b0; rev_req = 1'b0; flush = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [49:0] exp_mask(input int s);
    logic [63:0] m;
    m = (s == 0) ? 64'd0 : ((64'd1 << s) - 64'd1);
    return m[49:0];
  endfunction

  initial begin
    // Directed table, hand-computed expectations.
    vecs[0]  = mk(1,  5, 0, 0, 0,  0,  0,  0, 50'h0,  1, 1, 0, 0);
    vecs[1]  = mk(1,  0, 0, 0, 0,  0,  0,  0, 50'h0,  2, 1, 0, 0);
    vecs[2]  = mk(1, 50, 0, 0, 0,  0,  0,  0, 50'h0,  3, 1, 0, 0);
    vecs[3]  = mk(0,  0, 1, 0, 1, 46, 46,  5, 50'h1F, 2, 1, 0, 0);
    vecs[4]  = mk(0,  0, 1, 0, 1,  0,  0,  0, 50'h0,  1, 1, 0, 0);
    vecs[5]  = mk(0,  0, 1, 0, 1,  1,  1, 50, ALL1,   0, 1, 0, 0);
    vecs[6]  = mk(0,  0, 0, 0, 0,  1,  1, 50, ALL1,   0, 1, 0, 0);
    vecs[7]  = mk(0,  0, 1, 0, 0,  1,  1, 50, ALL1,   0, 1, 0, 1);
    vecs[8]  = mk(1, 55, 0, 0, 0,  1,  1, 50, ALL1,   1, 1, 1, 1);
    vecs[9]  = mk(1,  7, 1, 0, 1,  0,  0,  0, 50'h0,  1, 1, 1, 1);
    vecs[10] = mk(0,  0, 1, 0, 1, 44, 44,  7, 50'h7F, 0, 1, 1, 1);
    vecs[11] = mk(1,  9, 1, 0, 0, 44, 44,  7, 50'h7F, 1, 1, 1, 1);
    vecs[12] = mk(1,  3, 1, 1, 0, 44, 44,  7, 50'h7F, 0, 1, 1, 1);

    do_reset();
    check_vec("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 50'h0, 0, 1, 0, 0));

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].fv, vecs[i].fs, vecs[i].rr, vecs[i].fl);
      check_vec($sformatf("vec%0d", i), vecs[i]);
      $display("vec %0d: fv=%0d fs=%0d rr=%0d fl=%0d -> rv=%0d inv=%0d occ=%0d",
               i, vecs[i].fv, vecs[i].fs, vecs[i].rr, vecs[i].fl, rev_valid, inv_shift, occupancy);
    end

    // Fill to full, drop extra pushes, then push+pop while full.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 6'(i), 0, 0);
    check("full.occupancy", 64'(occupancy), 64'd8);
    check("full.fwd_ready", 64'(fwd_ready), 64'd0);
    step(1, 6'd9, 0, 0);
    check("drop9.occupancy", 64'(occupancy), 64'd8);
    check("drop9.err_range", 64'(err_range), 64'd0);
    step(1, 6'd10, 1, 0);
    check("fullpp.occupancy", 64'(occupancy), 64'd7);
    check("fullpp.rev_valid", 64'(rev_valid), 64'd1);
    check("fullpp.inv_shift", 64'(inv_shift), 64'd50);
    check("fullpp.right_sel", 64'(right_sel), 64'd1);
    check("fullpp.merge_sel", 64'(merge_sel), 64'd1);
    $display("full: pushed 1..8, 9 and 10 dropped, occ=%0d", occupancy);
    for (int i = 2; i <= 8; i++) begin
      step(0, 0, 1, 0);
      check($sformatf("drain%0d.right_sel", i), 64'(right_sel), 64'(i));
      check($sformatf("drain%0d.inv_shift", i), 64'(inv_shift), 64'(51 - i));
    end
    check("drained.occupancy", 64'(occupancy), 64'd0);
    step(0, 0, 0, 0);
    check("hold.rev_valid", 64'(rev_valid), 64'd0);
    check("hold.inv_shift", 64'(inv_shift), 64'd43);

    // Flush with three queued entries and both error flags set.
    step(0, 0, 1, 0);
    step(1, 6'd3, 0, 0);
    step(1, 6'd4, 0, 0);
    step(1, 6'd60, 0, 0);
    check("preflush.occupancy", 64'(occupancy), 64'd3);
    step(0, 0, 0, 1);
    check("flush.occupancy", 64'(occupancy), 64'd0);
    check("flush.err_range", 64'(err_range), 64'd1);
    check("flush.err_underflow", 64'(err_underflow), 64'd1);
    check("flush.inv_shift", 64'(inv_shift), 64'd43);
    $display("flush: occ=%0d err_r=%0d err_u=%0d", occupancy, err_range, err_underflow);

    // Reset mid-stream.
    step(1, 6'd11, 0, 0);
    step(1, 6'd12, 1, 0);
    rst = 1'b1;
    step(1, 6'd13, 1, 0);
    rst = 1'b0;
    check_vec("midrst", mk(0, 0, 0, 0, 0, 0, 0, 0, 50'h0, 0, 1, 0, 0));
    $display("mid-stream reset: occ=%0d ready=%0d", occupancy, fwd_ready);

    // Randomized stress against a reference queue.
    begin
      int q[$];
      logic exp_er;
      logic exp_eu;
      int pops;
      exp_er = 1'b0; exp_eu = 1'b0; pops = 0;
      for (int c = 0; c < 1000; c++) begin
        logic fv, rr;
        int fs;
        bit pop_ok, push_ok;
        int s;
        fv = ($urandom_range(0, 99) < 55);
        rr = ($urandom_range(0, 99) < 45);
        fs = $urandom_range(0, 63);
        push_ok = fv && (q.size() != 8);
        pop_ok  = rr && (q.size() != 0);
        s = 0;
        if (rr && q.size() == 0) exp_eu = 1'b1;
        if (pop_ok) s = q.pop_front();
        if (push_ok) begin
          q.push_back((fs < 51) ? fs : 0);
          if (fs >= 51) exp_er = 1'b1;
        end
        step(fv, 6'(fs), rr, 0);
        check("rnd.rev_valid", 64'(rev_valid), 64'(pop_ok));
        check("rnd.occupancy", 64'(occupancy), 64'(q.size()));
        if (pop_ok) begin
          pops++;
          check("rnd.inv_sum", 64'((s + int'(inv_shift)) % 51), 64'd0);
          check("rnd.inv_shift", 64'(inv_shift), 64'((s == 0) ? 0 : 51 - s));
          check("rnd.left_sel", 64'(left_sel), 64'(inv_shift));
          check("rnd.right_sel", 64'(right_sel), 64'(s));
          check("rnd.merge_sel", 64'(merge_sel), 64'(exp_mask(s)));
        end
      end
      check("rnd.err_range", 64'(err_range), 64'(exp_er));
      check("rnd.err_underflow", 64'(err_underflow), 64'(exp_eu));
      $display("stress: 1000 cycles, %0d pops", pops);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
